w0rm_core_writeback_arbiter: RTL
================================

Name: w0rm_core_writeback_arbiter

Overview:
Writer side of the W0RM_Core_RegisterFile write port. It accepts results from two producers, the ALU and the memory unit, over valid/ready handshakes. Each producer has its own small FIFO, and a round-robin arbiter drains the FIFOs into the single register-file write port, one write per cycle. The block also exports a pending-write mask so decode can stall on RAW hazards.

Parameters:
DATA_WIDTH, 32, width of register data.
NUM_REGISTERS, 16, register count; ADDR_WIDTH = ceil(log2(NUM_REGISTERS)).
FIFO_DEPTH, 2, entries per producer FIFO (power of two, >=2).

Ports:
clk  in  1  clock; all logic on the rising edge.
reset_n  in  1  synchronous, active-low reset.
flush  in  1  synchronous pipeline flush.
alu_valid  in  1  ALU result valid.
alu_ready  out  1  ALU FIFO can accept.
alu_addr  in  ADDR_WIDTH  ALU destination register.
alu_data  in  DATA_WIDTH  ALU result.
mem_valid  in  1  memory result valid.
mem_ready  out  1  memory FIFO can accept.
mem_addr  in  ADDR_WIDTH  memory destination register.
mem_data  in  DATA_WIDTH  load data.
port_write_enable  out  1  register-file write strobe.
port_write_addr  out  ADDR_WIDTH  register-file write address.
port_write_data  out  DATA_WIDTH  register-file write data.
pending_mask  out  NUM_REGISTERS  bit i=1 while any queued or issuing write targets register i.
idle  out  1  both FIFOs empty and port_write_enable=0.

Behaviour:
- Reset (reset_n=0 at an edge):
  - Both FIFOs empty.
  - port_write_enable/addr/data = 0.
  - Round-robin pointer favours ALU.
  - pending_mask = 0, idle = 1.
  - alu_ready = mem_ready = 0 while reset_n=0.
- Handshake:
  - xx_ready = reset_n & ~flush & ~fifo_full (combinational, no dependence on xx_valid).
  - Push occurs on an edge where valid&ready. Addr/data are captured, and the producer's per-source order is preserved.
  - When full, ready=0. There is no same-cycle pop-to-push bypass.
- Arbitration, evaluated each cycle on FIFO heads present before the edge:
  - Only one head non-empty: grant it.
  - Both non-empty: grant the source not granted last. The pointer updates on every grant.
  - None: no grant.
  - An entry pushed at edge N is eligible for grant only from edge N+1. Empty-FIFO bypass is not allowed.
- Issue stage (registered):
  - On a grant at edge E, pop the head. port_write_enable=1 with that head's addr/data during the cycle after E, for exactly one cycle.
  - With no grant, port_write_enable=0; addr/data hold their last values.
  - Minimum latency from accept to write strobe: 1 cycle.
  - Sustained throughput: 1 write/cycle aggregate.
- pending_mask: combinational OR over all valid FIFO entries plus the issue register when port_write_enable=1. Duplicate targets are counted once. The bit clears in the cycle after the last matching write strobe.
- flush=1 at an edge:
  - Both FIFOs empty; no grant that edge.
  - Any valid input that edge is dropped, since ready=0.
  - Pointer returns to favour ALU.
  - A write already on port_write_enable in the flush cycle completes normally. port_write_enable=0 in the following cycle.
- reset_n=0 overrides flush. Reset mid-operation discards all queued writes, and port_write_enable deasserts the cycle after the reset edge.
- Cross-source writes to the same register are ordered by grant, not by arrival. Producers that need ordering must hold off using pending_mask.
- Occupancy counters must not wrap:
  - No push when full.
  - No pop when empty.
  - Simultaneous push and pop on the same FIFO leaves occupancy unchanged.

Test Plan:
1. Single write: after reset, ALU pushes addr=3, data=0xDEADBEEF at edge N → port_write_enable=1, addr=3, data=0xDEADBEEF in cycle N+1 only. pending_mask bit3=1 from N through N+1, then 0. idle returns to 1.
2. Round-robin: both FIFOs preloaded with two entries each (ALU r1,r2; MEM r5,r6), producers then idle → strobes in order r1,r5,r2,r6 on 4 consecutive cycles.
3. Backpressure: ALU valid held high with FIFO_DEPTH=2 while MEM keeps winning alternate slots → alu_ready drops after 2 unconsumed pushes. No entry is lost or duplicated; the output data sequence matches the input sequence 0x10,0x11,0x12,...
4. Flush: 2 ALU entries queued plus one write issuing; assert flush for 1 cycle → the issuing write completes. No further strobes occur, pending_mask=0 the cycle after flush, and the input presented during flush is not written.
5. Reset mid-stream: with both FIFOs full, pull reset_n low for 1 edge → the next cycle shows port_write_enable=0, idle=1, ready=0 during reset. After release, a new MEM write to r7 issues normally with the ALU-first pointer.
6. Same-register hazard: ALU and MEM both target r4 → pending_mask bit4 stays 1 until the second strobe for r4 completes.

Source files
------------

// File: rtl/w0rm_core_writeback_arbiter.sv
// Register-file write-port arbiter: two producer FIFOs (ALU, memory) drained
// round-robin into one registered write port, with a RAW pending-write mask.

module w0rm_core_wb_fifo #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 16,
   parameter int FIFO_DEPTH    = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             flush,
   input  logic                             i_push,
   input  logic [$clog2(NUM_REGISTERS)-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0]            i_data,
   input  logic                             i_pop,
   output logic                             o_full,
   output logic                             o_empty,
   output logic [$clog2(NUM_REGISTERS)-1:0] o_head_addr,
   output logic [DATA_WIDTH-1:0]            o_head_data,
   output logic [NUM_REGISTERS-1:0]         o_pend_mask
);
   localparam int ADDR_WIDTH = $clog2(NUM_REGISTERS);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] r_addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W:0]        r_count;
   logic                  w_push;
   logic                  w_pop;
   logic [PTR_W-1:0]      w_offset;

   assign o_full      = (r_count == CNT_FULL);
   assign o_empty     = (r_count == '0);
   assign w_push      = i_push & ~o_full;
   assign w_pop       = i_pop & ~o_empty;
   assign o_head_addr = r_addr_q[r_rd_ptr];
   assign o_head_data = r_data_q[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr_q[r_wr_ptr] <= i_addr;
         r_data_q[r_wr_ptr] <= i_data;
      end
   end

   // A slot is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      o_pend_mask = '0;
      w_offset    = '0;
      for (int s = 0; s < FIFO_DEPTH; s++) begin
         w_offset = PTR_W'(s) - r_rd_ptr;
         if ({1'b0, w_offset} < r_count) begin
            for (int r = 0; r < NUM_REGISTERS; r++) begin
               if (r_addr_q[s] == ADDR_WIDTH'(r)) o_pend_mask[r] = 1'b1;
            end
         end
      end
   end
endmodule

module w0rm_core_writeback_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 16,
   parameter int FIFO_DEPTH    = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             flush,
   input  logic                             alu_valid,
   output logic                             alu_ready,
   input  logic [$clog2(NUM_REGISTERS)-1:0] alu_addr,
   input  logic [DATA_WIDTH-1:0]            alu_data,
   input  logic                             mem_valid,
   output logic                             mem_ready,
   input  logic [$clog2(NUM_REGISTERS)-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0]            mem_data,
   output logic                             port_write_enable,
   output logic [$clog2(NUM_REGISTERS)-1:0] port_write_addr,
   output logic [DATA_WIDTH-1:0]            port_write_data,
   output logic [NUM_REGISTERS-1:0]         pending_mask,
   output logic                             idle
);
   localparam int ADDR_WIDTH = $clog2(NUM_REGISTERS);

   logic                     w_alu_full,  w_mem_full;
   logic                     w_alu_empty, w_mem_empty;
   logic [ADDR_WIDTH-1:0]    w_alu_head_addr, w_mem_head_addr;
   logic [DATA_WIDTH-1:0]    w_alu_head_data, w_mem_head_data;
   logic [NUM_REGISTERS-1:0] w_alu_pend, w_mem_pend, w_issue_mask;
   logic                     w_alu_push, w_mem_push;
   logic                     w_gnt_alu, w_gnt_mem;
   logic                     r_prefer_mem;
   logic                     r_wen_p1;
   logic [ADDR_WIDTH-1:0]    r_waddr_p1;
   logic [DATA_WIDTH-1:0]    r_wdata_p1;

   assign alu_ready  = reset_n & ~flush & ~w_alu_full;
   assign mem_ready  = reset_n & ~flush & ~w_mem_full;
   assign w_alu_push = alu_valid & alu_ready;
   assign w_mem_push = mem_valid & mem_ready;

   w0rm_core_wb_fifo #(
      .DATA_WIDTH    (DATA_WIDTH),
      .NUM_REGISTERS (NUM_REGISTERS),
      .FIFO_DEPTH    (FIFO_DEPTH)
   ) u_alu_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (flush),
      .i_push      (w_alu_push),
      .i_addr      (alu_addr),
      .i_data      (alu_data),
      .i_pop       (w_gnt_alu),
      .o_full      (w_alu_full),
      .o_empty     (w_alu_empty),
      .o_head_addr (w_alu_head_addr),
      .o_head_data (w_alu_head_data),
      .o_pend_mask (w_alu_pend)
   );

   w0rm_core_wb_fifo #(
      .DATA_WIDTH    (DATA_WIDTH),
      .NUM_REGISTERS (NUM_REGISTERS),
      .FIFO_DEPTH    (FIFO_DEPTH)
   ) u_mem_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (flush),
      .i_push      (w_mem_push),
      .i_addr      (mem_addr),
      .i_data      (mem_data),
      .i_pop       (w_gnt_mem),
      .o_full      (w_mem_full),
      .o_empty     (w_mem_empty),
      .o_head_addr (w_mem_head_addr),
      .o_head_data (w_mem_head_data),
      .o_pend_mask (w_mem_pend)
   );

   // Grant uses only heads already stored, so a fresh push waits one edge.
   always_comb begin
      w_gnt_alu = 1'b0;
      w_gnt_mem = 1'b0;
      if (reset_n && !flush) begin
         if (!w_alu_empty && !w_mem_empty) begin
            w_gnt_alu = ~r_prefer_mem;
            w_gnt_mem = r_prefer_mem;
         end else if (!w_alu_empty) begin
            w_gnt_alu = 1'b1;
         end else if (!w_mem_empty) begin
            w_gnt_mem = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         r_prefer_mem <= 1'b0;
      end else if (w_gnt_alu) begin
         r_prefer_mem <= 1'b1;
      end else if (w_gnt_mem) begin
         r_prefer_mem <= 1'b0;
      end
   end

   // Issue stage: p0 = FIFO heads, p1 = register-file write port.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wen_p1   <= 1'b0;
         r_waddr_p1 <= '0;
         r_wdata_p1 <= '0;
      end else begin
         r_wen_p1 <= w_gnt_alu | w_gnt_mem;
         if (w_gnt_alu) begin
            r_waddr_p1 <= w_alu_head_addr;
            r_wdata_p1 <= w_alu_head_data;
         end else if (w_gnt_mem) begin
            r_waddr_p1 <= w_mem_head_addr;
            r_wdata_p1 <= w_mem_head_data;
         end
      end
   end

   always_comb begin
      w_issue_mask = '0;
      if (r_wen_p1) begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            if (r_waddr_p1 == ADDR_WIDTH'(r)) w_issue_mask[r] = 1'b1;
         end
      end
   end

   assign port_write_enable = r_wen_p1;
   assign port_write_addr   = r_waddr_p1;
   assign port_write_data   = r_wdata_p1;
   assign pending_mask      = w_alu_pend | w_mem_pend | w_issue_mask;
   assign idle              = w_alu_empty & w_mem_empty & ~r_wen_p1;
endmodule
